// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation codes and widths.
package univ_shift_reg_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_ASR  = 3'd6,
        MODE_CLR  = 3'd7
    } mode_e;

endpackage

// File: rtl/univ_shift_next.sv
// Combinational next-word selector for the universal shift register.
// A single-bit word cannot be sliced as [WIDTH-2:0], so the 1-bit case
// gets its own mux where shifts take SerIn and rotates/ASR hold.
module univ_shift_next
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  i_q,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [WIDTH-1:0]  i_d,
    input  logic              i_ser_in,
    output logic [WIDTH-1:0]  o_next
);

    generate
        if (WIDTH == 1) begin : g_single
            // Single-bit word: shifts replace the bit, rotates and ASR keep it.
            always_comb begin
                o_next = i_q;
                case (mode_e'(i_mode))
                    MODE_LOAD: o_next = i_d;
                    MODE_SHL:  o_next = i_ser_in;
                    MODE_SHR:  o_next = i_ser_in;
                    MODE_CLR:  o_next = '0;
                    default:   o_next = i_q;
                endcase
            end
        end else begin : g_multi
            // Multi-bit word: full operation set.
            always_comb begin
                o_next = i_q;
                case (mode_e'(i_mode))
                    MODE_LOAD: o_next = i_d;
                    MODE_SHL:  o_next = {i_q[WIDTH-2:0], i_ser_in};
                    MODE_SHR:  o_next = {i_ser_in, i_q[WIDTH-1:1]};
                    MODE_ROL:  o_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
                    MODE_ROR:  o_next = {i_q[0], i_q[WIDTH-1:1]};
                    MODE_ASR:  o_next = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
                    MODE_CLR:  o_next = '0;
                    default:   o_next = i_q;
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: hold, load, shift, rotate, arithmetic shift and clear,
// with clock enable and synchronous active-low reset. Reset outranks enable,
// and enable outranks the selected operation, so X on the data/mode inputs
// cannot reach Q while either is inactive.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [63:0] RESET_VALUE = 64'h0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [WIDTH-1:0]  i_d,
    input  logic              i_ser_in,
    output logic [WIDTH-1:0]  o_q,
    output logic              o_ser_out_l,
    output logic              o_ser_out_r,
    output logic              o_zero
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    univ_shift_next #(.WIDTH(WIDTH)) u_next (
        .i_q      (r_q),
        .i_mode   (i_mode),
        .i_d      (i_d),
        .i_ser_in (i_ser_in),
        .o_next   (w_next)
    );

    // Word register: reset first, then enable-gated update.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q <= RESET_VALUE[WIDTH-1:0];
        end else if (i_enable) begin
            r_q <= w_next;
        end
    end

    assign o_q         = r_q;
    assign o_ser_out_l = r_q[WIDTH-1];
    assign o_ser_out_r = r_q[0];
    assign o_zero      = (r_q == '0);

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register, the next generation of the single-bit D flip-flop. It holds a WIDTH-bit word and supports hold, parallel load, logical shifts, rotates, arithmetic shift right and clear, with a clock enable. It is the general storage/serialisation element for the lab datapaths, used for shift-and-add multipliers, serial I/O and accumulators.

Parameters:
WIDTH, 8, register width in bits; legal range 1 to 64.
RESET_VALUE, 0, value Q takes on reset; WIDTH bits, and higher bits are ignored.

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-low reset (sampled on rising edge of Clock)
Enable  input  1  clock enable; 0 holds Q regardless of Mode
Mode  input  3  operation select (encoding below)
D  input  WIDTH  parallel load data
SerIn  input  1  serial input bit for logical shifts
Q  output  WIDTH  registered contents
SerOutL  output  1  Q[WIDTH-1], combinational from Q
SerOutR  output  1  Q[0], combinational from Q
Zero  output  1  1 when Q == 0, combinational from Q

Behaviour:
- All state updates occur on the rising edge of Clock only. There is no asynchronous path; Reset low between edges has no effect until the next edge.
- Priority at each edge: Reset==0 -> Q=RESET_VALUE. Otherwise Enable==0 -> hold. Otherwise apply Mode.
- Reset state: Q=RESET_VALUE, so SerOutL/SerOutR/Zero follow from it (Zero=1 for default).
- Mode encoding, applied with Enable=1:
  - 0 HOLD: Q unchanged.
  - 1 LOAD: Q=D.
  - 2 SHL: Q={Q[WIDTH-2:0],SerIn}.
  - 3 SHR: Q={SerIn,Q[WIDTH-1:1]}.
  - 4 ROL: Q={Q[WIDTH-2:0],Q[WIDTH-1]}.
  - 5 ROR: Q={Q[0],Q[WIDTH-1:1]}.
  - 6 ASR: Q={Q[WIDTH-1],Q[WIDTH-1:1]}.
  - 7 CLR: Q=0 (not RESET_VALUE).
- Latency: one cycle. The new Q is visible after the edge on which the operation is sampled. Outputs derived from Q settle in the same cycle.
- WIDTH==1 degenerate cases: SHL/SHR -> Q=SerIn; ROL/ROR/ASR -> hold; SerOutL==SerOutR==Q.
- X on Mode/D/SerIn while Reset==0 or Enable==0 must not corrupt Q.
- Reset mid-sequence (e.g. during a shift burst) discards the operation on that edge. The next enabled edge operates on RESET_VALUE.
- No internal state other than Q. Back-to-back operations of any mode are legal every cycle.

Decomposition:
- Shared package: mode constants MODE_HOLD=0, MODE_LOAD=1, MODE_SHL=2, MODE_SHR=3, MODE_ROL=4, MODE_ROR=5, MODE_ASR=6, MODE_CLR=7, and the MODE_W=3 width constant.
- One natural sub-module: univ_shift_next, a combinational next-state mux (Q, Mode, D, SerIn -> next Q) handling the WIDTH==1 special case. The top level holds only the register, enable/reset priority and output taps.

Test Plan:
1. Reset=0 for two edges with D=8'hA5, Mode=LOAD, Enable=1 -> Q=8'h00, Zero=1. Release Reset, one edge -> Q=8'hA5, Zero=0, SerOutL=1, SerOutR=1.
2. Q=8'hA5, Mode=SHL, SerIn=0, three edges -> Q=8'h4A, 8'h94, 8'h28. Then Mode=SHR, SerIn=1, one edge -> Q=8'h94.
3. Q=8'h81, Mode=ROL, one edge -> 8'h03. Then Mode=ROR, two edges -> 8'h81, 8'hC0. Then Mode=ASR, one edge -> 8'hE0.
4. Q=8'h3C, Enable=0, Mode cycling through all 8 values for 8 edges -> Q stays 8'h3C. Then Enable=1, Mode=CLR -> Q=8'h00, Zero=1.
5. RESET_VALUE=8'h5A instance, Q=8'hFF mid-SHL burst; Reset=0 pulsed low between edges then raised before the edge -> no reset. Reset=0 held across an edge -> Q=8'h5A. Next edge with SHL, SerIn=1 -> 8'hB5.
6. WIDTH=1 instance: LOAD D=1 -> Q=1. ROL/ROR/ASR each -> Q=1. SHL SerIn=0 -> Q=0, SerOutL=SerOutR=0, Zero=1.
